// File: rtl/lane_collector_pkg.sv
// Shared types and helpers for the lane result collector.
package lane_collector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT    = 2'd2
  } lc_state_t;

  // Mask with the low n bits set; n is clamped to 32.
  function automatic logic [31:0] all_ones(input int n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/lane_collector_fifo.sv
// Synchronous FIFO for completed words; registered pointers, no write-to-read bypass.
module lane_collector_fifo
  import lane_collector_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count do, and rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_collector.sv
// Collects one result bit per lane into a word and streams completed words out through a FIFO.
module lane_collector
  import lane_collector_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] lane_vld,
  input  logic [NUM_LANES-1:0] lane_y,
  output logic                 lane_rdy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_LANES-1:0] out_data,
  output logic                 dup_err,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam logic [NUM_LANES-1:0] ALL = NUM_LANES'(all_ones(NUM_LANES));

  lc_state_t            state;
  logic [NUM_LANES-1:0] cap;
  logic [NUM_LANES-1:0] data;

  logic [NUM_LANES-1:0] accepted;
  logic [NUM_LANES-1:0] new_cap;
  logic [NUM_LANES-1:0] cap_nx;
  logic [NUM_LANES-1:0] data_nx;
  logic [NUM_LANES-1:0] push_data;
  logic                 dup;
  logic                 complete;
  logic                 pop;
  logic                 space;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign space     = ~fifo_full | pop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accepted  = '0;
    new_cap   = '0;
    cap_nx    = cap;
    data_nx   = data;
    dup       = 1'b0;
    complete  = 1'b0;
    push      = 1'b0;
    push_data = data;
    if (lane_rdy) begin
      accepted = lane_vld;
      new_cap  = accepted & ~cap;
      dup      = |(accepted & cap);
      cap_nx   = cap | new_cap;
      data_nx  = (data & ~new_cap) | (lane_y & new_cap);
      complete = (cap_nx == ALL);
      push     = complete & space;
      push_data = data_nx;
    end else if (state == WAIT) begin
      push = space;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap      <= '0;
      data     <= '0;
      lane_rdy <= 1'b1;
      dup_err  <= 1'b0;
      word_cnt <= '0;
    end else begin
      // A duplicate in the clearing cycle takes priority over err_clr.
      if (dup)          dup_err <= 1'b1;
      else if (err_clr) dup_err <= 1'b0;

      if (push) word_cnt <= word_cnt + CNT_W'(1);

      case (state)
        IDLE, COLLECT: begin
          if (complete && space) begin
            cap   <= '0;
            data  <= '0;
            state <= IDLE;
          end else if (complete) begin
            cap      <= cap_nx;
            data     <= data_nx;
            lane_rdy <= 1'b0;
            state    <= WAIT;
          end else begin
            cap   <= cap_nx;
            data  <= data_nx;
            state <= (cap_nx != '0) ? COLLECT : IDLE;
          end
        end
        WAIT: begin
          if (space) begin
            cap      <= '0;
            data     <= '0;
            lane_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          cap      <= '0;
          data     <= '0;
          lane_rdy <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  lane_collector_fifo #(
    .WIDTH (NUM_LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
